// File: rtl/four_bit_sync_counter_161.sv
// 4-bit synchronous counter with parallel load, dual count enables and ripple carry.
// DECADE selects binary (0..15) or BCD (0..9) sequencing; CLR_n clears asynchronously.
module four_bit_sync_counter_161 #(
    parameter int Delay  = 0,
    parameter bit DECADE = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR_n,
    input  logic       LOAD_n,
    input  logic       ENP,
    input  logic       ENT,
    input  logic [3:0] D,
    output logic [3:0] Q,
    output logic       RCO
);

    localparam logic [3:0] TC = DECADE ? 4'd9 : 4'd15;

    logic [3:0] q_r;
    logic [3:0] q_next_s;
    logic       rco_s;

    // Decade mode folds 9 and the illegal codes 10..15 back to zero.
    function automatic logic [3:0] next_count(input logic [3:0] cur);
        logic [3:0] nxt;
        if (DECADE) begin
            if (cur >= 4'd9) begin
                nxt = 4'd0;
            end else begin
                nxt = cur + 4'd1;
            end
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

    // Propagation delay is a simulation-only notion; hardware is zero-delay.
    if (Delay != 0) begin : g_delay_ignored
    end

    // Next state: load has priority over count, count over hold.
    always_comb begin
        q_next_s = q_r;
        if (!LOAD_n) begin
            q_next_s = D;
        end else if (ENP && ENT) begin
            q_next_s = next_count(q_r);
        end else begin
            q_next_s = q_r;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            q_r <= 4'd0;
        end else begin
            q_r <= q_next_s;
        end
    end

    // Carry is combinational so cascaded stages see it within the same cycle.
    always_comb begin
        rco_s = 1'b0;
        if (ENT && (q_r == TC)) begin
            rco_s = 1'b1;
        end else begin
            rco_s = 1'b0;
        end
    end

    assign Q   = q_r;
    assign RCO = rco_s;

endmodule

// File: tb/tb_four_bit_sync_counter_161.sv
// Directed bench: binary, decade, NAND mod-6 feedback and a two-digit BCD cascade.
module tb_four_bit_sync_counter_161;

    logic clk;
    int   checks;
    int   errors;

    logic       b_clr, b_load, b_enp, b_ent, b_rco;
    logic [3:0] b_d, b_q;
    logic       d_clr, d_load, d_enp, d_ent, d_rco;
    logic [3:0] d_d, d_q;
    logic       m_clr, m_load_s, m_rco;
    logic [3:0] m_q;
    logic       c_clr, c_en, u_rco, t_rco;
    logic [3:0] u_q, t_q;

    four_bit_sync_counter_161 #(.Delay(0), .DECADE(1'b0)) dut_bin (
        .CLK(clk), .CLR_n(b_clr), .LOAD_n(b_load), .ENP(b_enp), .ENT(b_ent),
        .D(b_d), .Q(b_q), .RCO(b_rco));

    four_bit_sync_counter_161 #(.Delay(0), .DECADE(1'b1)) dut_dec (
        .CLK(clk), .CLR_n(d_clr), .LOAD_n(d_load), .ENP(d_enp), .ENT(d_ent),
        .D(d_d), .Q(d_q), .RCO(d_rco));

    assign m_load_s = ~(m_q[2] & m_q[0]);

    four_bit_sync_counter_161 #(.Delay(0), .DECADE(1'b0)) dut_mod6 (
        .CLK(clk), .CLR_n(m_clr), .LOAD_n(m_load_s), .ENP(1'b1), .ENT(1'b1),
        .D(4'd0), .Q(m_q), .RCO(m_rco));

    four_bit_sync_counter_161 #(.Delay(0), .DECADE(1'b1)) dut_units (
        .CLK(clk), .CLR_n(c_clr), .LOAD_n(1'b1), .ENP(1'b1), .ENT(c_en),
        .D(4'd0), .Q(u_q), .RCO(u_rco));

    four_bit_sync_counter_161 #(.Delay(0), .DECADE(1'b1)) dut_tens (
        .CLK(clk), .CLR_n(c_clr), .LOAD_n(1'b1), .ENP(1'b1), .ENT(u_rco),
        .D(4'd0), .Q(t_q), .RCO(t_rco));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        logic       r;
        clk = 1'b0; checks = 0; errors = 0;
        b_clr = 1'b0; b_load = 1'b1; b_enp = 1'b0; b_ent = 1'b0; b_d = 4'd0;
        d_clr = 1'b0; d_load = 1'b1; d_enp = 1'b0; d_ent = 1'b0; d_d = 4'd0;
        m_clr = 1'b0; c_clr = 1'b0; c_en = 1'b0;
        tick();
        chk("bin_reset_q", b_q, 4'd0);
        chk("bin_reset_rco", {3'd0, b_rco}, 4'd0);
        chk("dec_reset_q", d_q, 4'd0);

        // Async clear with no clock edge from Q=7
        b_clr = 1'b1; b_load = 1'b0; b_d = 4'd7;
        tick();
        chk("bin_load7", b_q, 4'd7);
        b_load = 1'b1; b_enp = 1'b1; b_ent = 1'b1;
        b_clr = 1'b0;
        #1;
        chk("clr_async_q", b_q, 4'd0);
        chk("clr_async_rco", {3'd0, b_rco}, 4'd0);
        tick();
        chk("clr_edge_ignored", b_q, 4'd0);
        b_clr = 1'b1;
        tick();
        chk("clr_release_count", b_q, 4'd1);

        // Binary count from 0 for 17 edges
        b_load = 1'b0; b_d = 4'd0;
        tick();
        chk("bin_load0", b_q, 4'd0);
        b_load = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            e = 4'(i % 16);
            r = (e == 4'd15);
            chk("bin_count_q", b_q, e);
            chk("bin_count_rco", {3'd0, b_rco}, {3'd0, r});
        end
        for (int i = 0; i < 14; i++) tick();
        chk("bin_at15_q", b_q, 4'd15);
        chk("bin_at15_rco", {3'd0, b_rco}, 4'd1);
        b_ent = 1'b0;
        #1;
        chk("bin_rco_ent0", {3'd0, b_rco}, 4'd0);
        tick();
        chk("bin_hold_ent0", b_q, 4'd15);

        // Load priority over count, then hold with ENP=0
        b_ent = 1'b1; b_enp = 1'b1; b_load = 1'b0; b_d = 4'b1010;
        tick();
        chk("load_priority", b_q, 4'd10);
        b_d = 4'd5;
        tick();
        chk("load5", b_q, 4'd5);
        b_load = 1'b1; b_enp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_enp0", b_q, 4'd5);
        end
        b_load = 1'b0; b_d = 4'd15;
        tick();
        chk("load_tc_q", b_q, 4'd15);
        chk("load_tc_rco", {3'd0, b_rco}, 4'd1);

        // Decade count
        d_clr = 1'b1; d_enp = 1'b1; d_ent = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            e = 4'(i % 10);
            r = (e == 4'd9);
            chk("dec_count_q", d_q, e);
            chk("dec_count_rco", {3'd0, d_rco}, {3'd0, r});
        end
        d_load = 1'b0; d_d = 4'd12;
        tick();
        chk("dec_load12_q", d_q, 4'd12);
        chk("dec_load12_rco", {3'd0, d_rco}, 4'd0);
        d_load = 1'b1;
        tick();
        chk("dec_recover_q", d_q, 4'd0);
        chk("dec_recover_rco", {3'd0, d_rco}, 4'd0);

        // Mod-6 via NAND feedback into LOAD_n
        m_clr = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk("mod6_q", m_q, 4'(i % 6));
        end

        // Two-digit BCD cascade
        c_clr = 1'b1; c_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("casc_units", u_q, 4'(i % 10));
            chk("casc_tens", t_q, 4'((i % 100) / 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_sync_counter_161.md
Name: four_bit_sync_counter_161

Overview:
- 4-bit synchronous counter with synchronous parallel load, two count enables and a ripple-carry output.
- Modelled on the 74LS161 (binary) and 74LS160 (decade) parts in the 74-series IP catalog.
- Sits directly upstream of the quad 2-input NAND IP in the digital clock: Q outputs feed NAND decode, and the NAND output drives LOAD_n back for mod-N counting (seconds/minutes mod-6/mod-10 stages).
- RCO cascades into the next counter's ENT.

Parameters:
Delay, 0, output propagation delay in ns applied to Q and RCO; simulation only, ignored by synthesis
DECADE, 0, 0 = binary count 0..15 (161 behaviour); 1 = BCD count 0..9 (160 behaviour)

Ports:
CLK  input  1  clock; all state changes on rising edge except clear
CLR_n  input  1  asynchronous, active-low clear
LOAD_n  input  1  synchronous active-low parallel load
ENP  input  1  count enable P (does not gate RCO)
ENT  input  1  count enable T (also gates RCO)
D  input  4  parallel load data, D[3] = MSB
Q  output  4  counter state, Q[3] = MSB
RCO  output  1  ripple carry out

Behaviour:
- Interface: one clock, CLK. Reset is CLR_n, asynchronous and active-low.
- Reset values:
  - CLR_n low forces Q=4'b0000 immediately, independent of CLK.
  - RCO = 0 while cleared, since Q is not at terminal count.
  - While CLR_n is low, rising edges of CLK are ignored.
  - Counting resumes on the first rising edge after CLR_n deasserts.
- Priority at each rising edge with CLR_n high: LOAD_n low > count (ENP=1 and ENT=1) > hold.
- Load:
  - LOAD_n low at the edge sets Q <= D, regardless of ENP/ENT.
  - Latency is 1 clock; no combinational path from D to Q.
- Count: ENP=ENT=1 and LOAD_n high gives Q <= next(Q).
  - DECADE=0: next(Q) = Q+1 mod 16; 15 wraps to 0.
  - DECADE=1: next(Q) = Q+1 for Q<9; 0 for Q>=9. Illegal loaded values 10..15 recover to 0 on the next count edge.
- Hold: ENP=0 or ENT=0 (LOAD_n high) leaves Q unchanged.
- RCO:
  - Combinational: RCO = ENT AND (Q == TC), where TC = 15 for binary and 9 for decade. No clock latency.
  - RCO ignores ENP and LOAD_n.
  - For DECADE=1 with an illegal Q of 10..15, RCO = 0.
- Simultaneous events:
  - CLR_n falling coincident with a CLK edge: clear wins, Q = 0.
  - LOAD_n low with ENP=ENT=1: load wins.
  - Loading D = TC with ENT=1 makes RCO rise in the same cycle Q updates.
- Reset mid-operation: clear asserted mid-count or mid-load aborts the operation. No state survives except Q=0.
- Delay: Q and RCO change Delay ns after their cause; Delay=0 means zero-delay.
- Cascading: stage n+1 ENT = stage n RCO, with a common CLK. This must give a correct synchronous multi-digit count with no extra logic.

Test Plan:
- Reset: CLR_n=0 with no CLK edge while Q=7 -> Q=0 immediately, RCO=0; a CLK edge while CLR_n=0 -> Q stays 0. Release, ENP=ENT=1 -> Q=1 after 1 edge.
- Binary count (DECADE=0): ENP=ENT=1 for 17 edges from 0 -> Q sequence 1..15,0,1. RCO=1 only while Q=15; RCO drops to 0 when ENT is forced 0 at Q=15.
- Decade count (DECADE=1): 11 edges from 0 -> 1..9,0,1 with RCO=1 only at Q=9. Load D=12, then count -> Q=12, then 0; RCO=0 throughout.
- Load priority: LOAD_n=0, D=4'b1010, ENP=ENT=1 -> Q=10 next edge, no increment. ENP=0, ENT=1, Q=5 -> hold at 5 for 3 edges.
- Mod-6 with NAND decode: NAND(Q[2],Q[0]) drives LOAD_n, D=0 -> Q cycles 0,1,2,3,4,5,0 continuously.
- Cascade: two DECADE=1 instances, RCO0->ENT1, run 100 edges from 00 -> tens:units reaches 9:9 then 0:0. Tens increments only on the edge where units goes 9->0.
